// File: rtl/seq_shift_right.sv
// Multi-cycle right shifter (SRL / SRA / ROR): one binary-weighted stage (1,2,4,8,...) per clock.
// Latency: start edge N -> busy N..N+SHW-1, done pulse after edge N+SHW (earlier with SHR_EARLY_DONE_EN).
// Backpressure: none queued; start is only honoured in IDLE or DONE, ignored while busy.
//
// Optional build macro: SHR_EARLY_DONE_EN -- finish as soon as no higher Shift_Val bits remain set.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             operation request, sampled in IDLE or DONE
//   Shift_In          operand, captured on accepted start
//   Shift_Val         shift amount, captured on accepted start
//   Mode              00 SRL, 01 SRA, 10 ROR, 11 executes as SRL
//   busy / done       stage application in progress / one-cycle completion pulse
//   Shift_Out         registered result, held until the next operation completes
module seq_shift_right #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Shift_In,
    input  logic [SHW-1:0]   Shift_Val,
    input  logic [1:0]       Mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Shift_Out
);

    localparam int IDXW = (SHW > 1) ? $clog2(SHW) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] shift_out_q, shift_out_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic [1:0]       mode_q, mode_d;
    logic             sign_q, sign_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic [SHW:0]       step;
    logic [WIDTH-1:0]   srl_val;
    logic [WIDTH-1:0]   fill_mask;
    logic [2*WIDTH-1:0] rot_wide;
    logic [WIDTH-1:0]   stage_out;
    logic               last_stage;

    // Single stage datapath: shift the working register by 2**idx when that amount bit is set.
    always_comb begin
        step      = (SHW+1)'(1) << idx_q;
        srl_val   = work_q >> step;
        // Ones in the vacated MSB positions; used to sign-fill for SRA.
        fill_mask = ~({WIDTH{1'b1}} >> step);
        // Rotating a doubled copy brings the LSBs shifted out back in at the top.
        rot_wide  = {work_q, work_q} >> step;
        stage_out = work_q;
        if (amt_q[idx_q]) begin
            case (mode_q)
                2'b01:   stage_out = srl_val | (sign_q ? fill_mask : '0);
                2'b10:   stage_out = rot_wide[WIDTH-1:0];
                default: stage_out = srl_val;
            endcase
        end
    end

`ifdef SHR_EARLY_DONE_EN
    // Finish once every amount bit above the current stage is clear.
    always_comb last_stage = ((amt_q >> idx_q) >> 1) == '0;
`else
    always_comb last_stage = (idx_q == IDXW'(SHW - 1));
`endif

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        shift_out_d = shift_out_q;
        amt_d       = amt_q;
        mode_d      = mode_q;
        sign_d      = sign_q;
        idx_d       = idx_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    work_d  = Shift_In;
                    amt_d   = Shift_Val;
                    mode_d  = Mode;
                    sign_d  = Shift_In[WIDTH-1];
                    idx_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_d = stage_out;
                idx_d  = idx_q + 1'b1;
                if (last_stage) begin
                    shift_out_d = stage_out;
                    idx_d       = '0;
                    state_d     = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            shift_out_q <= '0;
            amt_q       <= '0;
            mode_q      <= '0;
            sign_q      <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            shift_out_q <= shift_out_d;
            amt_q       <= amt_d;
            mode_q      <= mode_d;
            sign_q      <= sign_d;
            idx_q       <= idx_d;
        end
    end

    assign busy      = (state_q == S_SHIFT);
    assign done      = (state_q == S_DONE);
    assign Shift_Out = shift_out_q;

endmodule
